rom_burst_arb: RTL and testbench



---
 rtl/snn_rom_pkg.sv | 15 +
 rtl/rom_burst_arb_rr_pick.sv | 45 ++++
 rtl/rom_burst_arb.sv | 155 +++++++++++++++
 tb/tb_rom_burst_arb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_rom_pkg.sv
// rtl/snn_rom_pkg.sv - shared ROM geometry defaults and burst arbiter state encoding
package snn_rom_pkg;

  // Default geometry shared by the weight/threshold ROM instances and their arbiters.
  localparam int SNN_ROM_ADDR_WIDTH = 10;
  localparam int SNN_ROM_LEN_WIDTH  = 8;

  // Burst sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    LAST  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rom_burst_arb_rr_pick.sv
// rtl/rom_burst_arb_rr_pick.sv - combinational winner select, round-robin or fixed priority with ROM_BURST_ARB_PRIO_EN
module rr_pick
  import snn_rom_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_granted,
  output logic [NUM_REQ-1:0] winner
);

`ifdef ROM_BURST_ARB_PRIO_EN

  // Fixed priority keeps no history, so the previous winner is not consulted.
  logic unused_last_granted;
  assign unused_last_granted = ^last_granted;

  // Lowest index wins: isolate the least-significant set request bit.
  always_comb begin
    winner = req & (~req + NUM_REQ'(1));
  end

`else

  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk the ring starting just after the previous winner; the first pending requester wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_granted) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/rom_burst_arb.sv
// rtl/rom_burst_arb.sv - shared ROM burst arbiter and address sequencer (ROM_BURST_ARB_PRIO_EN selects fixed priority)
module rom_burst_arb
  import snn_rom_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = SNN_ROM_ADDR_WIDTH,
  parameter int LEN_WIDTH  = SNN_ROM_LEN_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   base_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    len_m1,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [ADDR_WIDTH-1:0]           rom_addr,
  output logic                            rd_valid,
  output logic                            rd_last,
  output logic [NUM_REQ-1:0]              done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_last_q, rd_last_d;
  logic [NUM_REQ-1:0]     done_q, done_d;

  logic [NUM_REQ-1:0]     winner;
  logic [ADDR_WIDTH-1:0]  win_base;
  logic [LEN_WIDTH-1:0]   win_len;
  logic [IDX_W-1:0]       last_gnt;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req          (req),
    .last_granted (last_gnt),
    .winner       (winner)
  );

`ifdef ROM_BURST_ARB_PRIO_EN

  assign last_gnt = '0;

`else

  logic [IDX_W-1:0] last_gnt_q, last_gnt_d;
  logic [IDX_W-1:0] gnt_idx;

  // Encode the held grant and advance the pointer past it as the burst retires.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        gnt_idx = IDX_W'(i);
      end
    end
    last_gnt_d = (state_q == LAST) ? gnt_idx : last_gnt_q;
  end

  // Pointer resets to the top index so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  assign last_gnt = last_gnt_q;

`endif

  // Route the winner's start address and length to the grant edge.
  always_comb begin
    win_base = '0;
    win_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        win_base = base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_len  = len_m1[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Burst sequencing: grant in IDLE, step the address through BURST, release after LAST.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rom_addr_d  = rom_addr_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d       = winner;
          rom_addr_d  = win_base;
          remaining_d = win_len;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (remaining_q != '0) begin
          rom_addr_d  = rom_addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end else begin
          state_d = LAST;
        end
      end
      LAST: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // The ROM registers the address, so its q trails the BURST cycle by one clock.
    rd_valid_d = (state_q == BURST);
    rd_last_d  = (state_q == BURST) && (remaining_q == '0);
    done_d     = rd_last_d ? gnt_q : '0;
  end

  // Sequencer state and all registered outputs; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rom_addr_q  <= '0;
      remaining_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rom_addr_q  <= rom_addr_d;
      remaining_q <= remaining_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      done_q      <= done_d;
    end
  end

  assign gnt      = gnt_q;
  assign rom_addr = rom_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rom_burst_arb.sv
// tb/tb_rom_burst_arb.sv - self-checking bench for rom_burst_arb with a timeline model and a behavioural ROM
module tb_rom_burst_arb;

  localparam int NUM_REQ = 2;
  localparam int AW      = 10;
  localparam int LW      = 8;
  localparam int MAXC    = 2048;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] base_addr;
  logic [NUM_REQ*LW-1:0] len_m1;
  logic [NUM_REQ-1:0]    gnt;
  logic [AW-1:0]         rom_addr;
  logic                  rd_valid;
  logic                  rd_last;
  logic [NUM_REQ-1:0]    done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rom_burst_arb #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .base_addr (base_addr),
    .len_m1    (len_m1),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .done      (done)
  );

  // Behavioural synchronous ROM with a recognisable content pattern.
  function automatic logic [15:0] rom_word(input logic [AW-1:0] a);
    return {6'd0, a} ^ 16'h5A3C;
  endfunction

  logic [15:0] rom_q;
  always @(posedge clk) rom_q <= rom_word(rom_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Timeline model: every grant writes its whole future into per-cycle expectation arrays.
  int                 cyc = 0;
  int                 free_cyc = 0;
  int                 last_g = NUM_REQ - 1;
  logic [NUM_REQ-1:0] e_gnt  [MAXC];
  logic [NUM_REQ-1:0] e_done [MAXC];
  logic [AW-1:0]      e_addr [MAXC];
  logic [AW-1:0]      e_word [MAXC];
  bit                 e_live [MAXC];
  bit                 e_valid[MAXC];
  bit                 e_last [MAXC];

  function automatic int pick(input logic [NUM_REQ-1:0] r, input int lg);
`ifdef ROM_BURST_ARB_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NUM_REQ; k++) if (r[(lg + k) % NUM_REQ]) return (lg + k) % NUM_REQ;
`endif
    return -1;
  endfunction

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      e_gnt[c] = '0; e_done[c] = '0; e_addr[c] = '0; e_word[c] = '0;
      e_live[c] = 0; e_valid[c] = 0; e_last[c] = 0;
    end
  end

  always @(posedge clk) begin : model
    int w;
    int l;
    logic [AW-1:0] b;
    if (!rst_n) begin
      for (int c = cyc + 1; c < MAXC; c++) begin
        e_gnt[c] = '0; e_done[c] = '0; e_live[c] = 0; e_valid[c] = 0; e_last[c] = 0;
      end
      free_cyc = 0;
      last_g   = NUM_REQ - 1;
    end else if (cyc >= free_cyc && req != '0 && cyc + 300 < MAXC) begin
      w = pick(req, last_g);
      b = base_addr[w*AW +: AW];
      l = int'(len_m1[w*LW +: LW]);
      for (int k = 0; k <= l; k++) begin
        e_live[cyc+1+k]  = 1;
        e_addr[cyc+1+k]  = AW'(int'(b) + k);
        e_valid[cyc+2+k] = 1;
        e_word[cyc+2+k]  = AW'(int'(b) + k);
      end
      for (int c = cyc + 1; c <= cyc + 2 + l; c++) e_gnt[c] = NUM_REQ'(1) << w;
      e_last[cyc+2+l] = 1;
      e_done[cyc+2+l] = NUM_REQ'(1) << w;
      free_cyc = cyc + 3 + l;
      last_g   = w;
    end
    cyc++;
  end

  // Compare every cycle on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin : compare
    if (!rst_n) begin
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_last", 32'(rd_last), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end else begin
      chk("gnt", 32'(gnt), 32'(e_gnt[cyc]));
      chk("rd_valid", 32'(rd_valid), 32'(e_valid[cyc]));
      chk("rd_last", 32'(rd_last), 32'(e_last[cyc]));
      chk("done", 32'(done), 32'(e_done[cyc]));
      if (e_live[cyc]) chk("rom_addr", 32'(rom_addr), 32'(e_addr[cyc]));
      if (e_valid[cyc]) chk("rd_data", 32'(rom_q), 32'(rom_word(e_word[cyc])));
    end
  end

  // Observation queues used by the literal per-test expectations.
  logic [AW-1:0] prev_addr = '0;
  int addr_q[$];
  int done_q[$];
  int vcyc_q[$];

  always @(negedge clk) begin : monitor
    if (rst_n && rd_valid) begin
      addr_q.push_back(int'(prev_addr));
      vcyc_q.push_back(cyc);
    end
    if (rst_n) for (int i = 0; i < NUM_REQ; i++) if (done[i]) done_q.push_back(i);
    prev_addr = rom_addr;
  end

  int left[NUM_REQ];

  task automatic clear_mon();
    addr_q.delete(); done_q.delete(); vcyc_q.delete();
  endtask

  // One clock of requester behaviour: drop req in the done cycle once its bursts are used up.
  task automatic tick();
    @(posedge clk);
    #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (done[i] && left[i] > 0) begin
        left[i]--;
        if (left[i] == 0) req[i] = 1'b0;
      end
    end
  endtask

  task automatic start(input int i, input logic [AW-1:0] b, input logic [LW-1:0] l, input int n);
    base_addr[i*AW +: AW] = b;
    len_m1[i*LW +: LW]    = l;
    left[i]               = n;
    req[i]                = 1'b1;
  endtask

  function automatic bit busy();
    for (int i = 0; i < NUM_REQ; i++) if (left[i] != 0) return 1'b1;
    return gnt != '0;
  endfunction

  task automatic wait_all(input string nm);
    int n = 0;
    while (busy() && n < 400) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, 32'(n >= 400), 32'd0);
    repeat (3) tick();
  endtask

  task automatic chk_q(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", nm, i), 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin : stim
    int e[$];
    int n;
    int seen;
    int ones;
    int threes;
    req = '0; base_addr = '0; len_m1 = '0;
    for (int i = 0; i < NUM_REQ; i++) left[i] = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);

    // Single burst of four words from 0x010.
    clear_mon();
    start(0, 10'h010, 8'd3, 1);
    wait_all("t1");
    e = '{'h010, 'h011, 'h012, 'h013};
    chk_q("t1_addr", addr_q, e);
    e = '{0};
    chk_q("t1_done", done_q, e);
    if (vcyc_q.size() == 4) chk("t1_contig", 32'(vcyc_q[3] - vcyc_q[0]), 32'd3);

    // Contention straight out of reset, two bursts each.
    @(posedge clk); #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_mon();
    start(0, 10'h020, 8'd1, 2);
    start(1, 10'h030, 8'd1, 2);
    wait_all("t2");
`ifdef ROM_BURST_ARB_PRIO_EN
    e = '{0, 0, 1, 1};
`else
    e = '{0, 1, 0, 1};
`endif
    chk_q("t2_order", done_q, e);

    // Single word at the top of the address space, then a wrapping burst.
    clear_mon();
    start(0, 10'h3FF, 8'd0, 1);
    wait_all("t3a");
    e = '{'h3FF};
    chk_q("t3a_addr", addr_q, e);
    e = '{0};
    chk_q("t3a_done", done_q, e);
    clear_mon();
    start(0, 10'h3FE, 8'd2, 1);
    wait_all("t3b");
    e = '{'h3FE, 'h3FF, 'h000};
    chk_q("t3b_addr", addr_q, e);

    // Inputs of the granted requester change mid-burst.
    clear_mon();
    start(1, 10'h100, 8'd4, 1);
    n = 0;
    while (!gnt[1] && n < 50) begin tick(); n++; end
    chk("t4_grant_seen", 32'(gnt[1]), 32'd1);
    tick(); tick();
    base_addr[AW +: AW] = 10'h155;
    len_m1[LW +: LW]    = 8'd9;
    wait_all("t4");
    e = '{'h100, 'h101, 'h102, 'h103, 'h104};
    chk_q("t4_addr", addr_q, e);

    // Reset during the second of five words; the pending request restarts afterwards.
    clear_mon();
    start(1, 10'h200, 8'd4, 1);
    seen = 0; n = 0;
    while (seen < 2 && n < 50) begin
      tick();
      if (rd_valid) seen++;
      n++;
    end
    chk("t5_reached_word2", 32'(seen), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t5_gnt_now", 32'(gnt), 32'd0);
    chk("t5_valid_now", 32'(rd_valid), 32'd0);
    chk("t5_addr_now", 32'(rom_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_all("t5");
    e = '{'h200, 'h200, 'h201, 'h202, 'h203, 'h204};
    chk_q("t5_addr", addr_q, e);
    e = '{1};
    chk_q("t5_done", done_q, e);

    // Back-to-back bursts from one requester holding req.
    clear_mon();
    start(1, 10'h040, 8'd7, 3);
    wait_all("t6");
    chk("t6_nvalid", 32'(vcyc_q.size()), 32'd24);
    ones = 0; threes = 0;
    for (int i = 1; i < vcyc_q.size(); i++) begin
      if (vcyc_q[i] - vcyc_q[i-1] == 1) ones++;
      else if (vcyc_q[i] - vcyc_q[i-1] == 3) threes++;
    end
    chk("t6_contig", 32'(ones), 32'd21);
    chk("t6_gaps", 32'(threes), 32'd2);
    e = '{1, 1, 1};
    chk_q("t6_done", done_q, e);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

endmodule
